// File: rtl/controlador_cursor.sv
// Cursor/menu controller for the 3x3 shape grid: edge moves, auto-repeat, confirm, timeout.
// Optional CURSOR_WRAP_EN: wrap around grid edges instead of saturating.
module controlador_cursor #(
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000,
    parameter int TIMEOUT       = 500000000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Arriba,
    input  logic       Abajo,
    input  logic       Izquierda,
    input  logic       Derecha,
    input  logic       Select,
    output logic [8:0] Cursor,
    output logic [1:0] Fila,
    output logic [1:0] Columna,
    output logic [3:0] Figura,
    output logic       Valida,
    output logic       Enter
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST = RW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT,
        LOCK
    } state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [TW-1:0] icnt_q, icnt_d;
    logic [4:0]    prev_q;

    logic [3:0] dir, dir_v;
    logic       one_hot, fresh, sel_edge, any_in;
    logic [1:0] mv_fila, mv_col;
    logic [1:0] fila_d, col_d;
    logic [3:0] fig_d;
    logic       val_d, ent_d;
    logic       do_move, do_confirm;
    logic [RW-1:0] r_last;

    function automatic logic [3:0] index(input logic [1:0] f, input logic [1:0] c);
        return {f, 2'b00} - {2'b00, f} + {2'b00, c};
    endfunction

    function automatic logic [1:0] inc3(input logic [1:0] v);
`ifdef CURSOR_WRAP_EN
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
`else
        return (v == 2'd2) ? 2'd2 : v + 2'd1;
`endif
    endfunction

    function automatic logic [1:0] dec3(input logic [1:0] v);
`ifdef CURSOR_WRAP_EN
        return (v == 2'd0) ? 2'd2 : v - 2'd1;
`else
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
`endif
    endfunction

    assign dir      = {Arriba, Abajo, Izquierda, Derecha};
    assign one_hot  = (dir != 4'd0) && ((dir & (dir - 4'd1)) == 4'd0);
    assign dir_v    = one_hot ? dir : 4'd0;
    assign fresh    = one_hot && (dir != prev_q[4:1]);
    assign sel_edge = Select && !prev_q[0];
    assign any_in   = |{dir, Select};
    assign r_last   = (state_q == HOLD) ? RD_LAST : RP_LAST;

    always_comb begin
        mv_fila = Fila;
        mv_col  = Columna;
        unique case (1'b1)
            dir_v[3]: mv_fila = dec3(Fila);
            dir_v[2]: mv_fila = inc3(Fila);
            dir_v[1]: mv_col  = dec3(Columna);
            dir_v[0]: mv_col  = inc3(Columna);
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rcnt_d     = rcnt_q;
        icnt_d     = icnt_q;
        fila_d     = Fila;
        col_d      = Columna;
        fig_d      = Figura;
        val_d      = Valida;
        ent_d      = 1'b0;
        do_move    = 1'b0;
        do_confirm = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (sel_edge) begin
                    do_confirm = 1'b1;
                end else if (fresh) begin
                    do_move = 1'b1;
                    rcnt_d  = '0;
                    icnt_d  = '0;
                    state_d = HOLD;
                end else if (any_in) begin
                    icnt_d = '0;
                end else if (icnt_q == TO_LAST) begin
                    fila_d = 2'd0;
                    col_d  = 2'd0;
                    icnt_d = '0;
                end else begin
                    icnt_d = icnt_q + TW'(1);
                end
            end
            HOLD, REPEAT: begin
                if (sel_edge) begin
                    do_confirm = 1'b1;
                end else if (!one_hot) begin
                    rcnt_d  = '0;
                    icnt_d  = '0;
                    state_d = IDLE;
                end else if (fresh) begin
                    do_move = 1'b1;
                    rcnt_d  = '0;
                    state_d = HOLD;
                end else if (rcnt_q == r_last) begin
                    // Edge-saturated moves still advance the repeat timing
                    do_move = 1'b1;
                    rcnt_d  = '0;
                    state_d = REPEAT;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
            LOCK: begin
                if (!any_in) begin
                    icnt_d  = '0;
                    rcnt_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_move) begin
            fila_d = mv_fila;
            col_d  = mv_col;
        end
        if (do_confirm) begin
            fig_d   = index(Fila, Columna);
            val_d   = 1'b1;
            ent_d   = 1'b1;
            rcnt_d  = '0;
            icnt_d  = '0;
            state_d = LOCK;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            rcnt_q  <= '0;
            icnt_q  <= '0;
            prev_q  <= '0;
            Fila    <= 2'd0;
            Columna <= 2'd0;
            Cursor  <= 9'd1;
            Figura  <= 4'd0;
            Valida  <= 1'b0;
            Enter   <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            icnt_q  <= icnt_d;
            prev_q  <= {dir, Select};
            Fila    <= fila_d;
            Columna <= col_d;
            Cursor  <= 9'd1 << index(fila_d, col_d);
            Figura  <= fig_d;
            Valida  <= val_d;
            Enter   <= ent_d;
        end
    end

endmodule

// File: tb/tb_controlador_cursor.sv
// Directed bench for controlador_cursor: vector table plus hold/timeout/reset sequences.
// Build with or without +define+CURSOR_WRAP_EN; expectations follow the define.
module tb_controlador_cursor;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Arriba, Abajo, Izquierda, Derecha, Select;
    logic [8:0] Cursor;
    logic [1:0] Fila, Columna;
    logic [3:0] Figura;
    logic       Valida, Enter;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [4:0] in;
        int         fila;
        int         col;
        int         fig;
        logic       val;
        logic       ent;
    } vec_t;

    vec_t tbl[$];

    controlador_cursor #(
        .REPEAT_DELAY (4),
        .REPEAT_PERIOD(2),
        .TIMEOUT      (8)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Arriba   (Arriba),
        .Abajo    (Abajo),
        .Izquierda(Izquierda),
        .Derecha  (Derecha),
        .Select   (Select),
        .Cursor   (Cursor),
        .Fila     (Fila),
        .Columna  (Columna),
        .Figura   (Figura),
        .Valida   (Valida),
        .Enter    (Enter)
    );

    always #5 Clk = ~Clk;

    // Input vector order: {Arriba, Abajo, Izquierda, Derecha, Select}
    task automatic drive(input logic [4:0] v);
        {Arriba, Abajo, Izquierda, Derecha, Select} = v;
    endtask

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    function automatic void add(input logic [4:0] i, input int f, input int c,
                                input int fg, input logic v, input logic e);
        vec_t t;
        t.in = i; t.fila = f; t.col = c; t.fig = fg; t.val = v; t.ent = e;
        tbl.push_back(t);
    endfunction

    task automatic check(input string name, input int f, input int c,
                         input int fg, input logic v, input logic e);
        logic [8:0] cexp;
        cexp = 9'd1 << (3 * f + c);
        total++;
        if (Fila === 2'(f) && Columna === 2'(c) && Cursor === cexp &&
            Figura === 4'(fg) && Valida === v && Enter === e) begin
            passed++;
        end else begin
            $display("FAIL %s: got fila=%0d col=%0d cursor=%h fig=%0d val=%b ent=%b, want fila=%0d col=%0d cursor=%h fig=%0d val=%b ent=%b",
                     name, Fila, Columna, Cursor, Figura, Valida, Enter,
                     f, c, cexp, fg, v, e);
        end
    endtask

    task automatic do_reset;
        Reset = 1'b1;
        drive(5'b00000);
        tick;
        tick;
        Reset = 1'b0;
    endtask

    initial begin
        int cexp[10];
        int endc;
        string nm;

`ifdef CURSOR_WRAP_EN
        cexp = '{1, 1, 1, 1, 2, 2, 0, 0, 1, 1};
        endc = 1;
`else
        cexp = '{1, 1, 1, 1, 2, 2, 2, 2, 2, 2};
        endc = 2;
`endif

        add(5'b00000, 0, 0, 0, 1'b0, 1'b0);
        add(5'b00010, 0, 1, 0, 1'b0, 1'b0);
        add(5'b01000, 1, 1, 0, 1'b0, 1'b0);
        add(5'b00001, 1, 1, 4, 1'b1, 1'b1);
        add(5'b00011, 1, 1, 4, 1'b1, 1'b0);
        add(5'b00011, 1, 1, 4, 1'b1, 1'b0);
        add(5'b00000, 1, 1, 4, 1'b1, 1'b0);
        add(5'b00100, 1, 0, 4, 1'b1, 1'b0);
        add(5'b00000, 1, 0, 4, 1'b1, 1'b0);
        add(5'b10100, 1, 0, 4, 1'b1, 1'b0);
        add(5'b00000, 1, 0, 4, 1'b1, 1'b0);
        add(5'b00011, 1, 0, 3, 1'b1, 1'b1);
        add(5'b00000, 1, 0, 3, 1'b1, 1'b0);
        add(5'b10000, 0, 0, 3, 1'b1, 1'b0);
        add(5'b00000, 0, 0, 3, 1'b1, 1'b0);
`ifdef CURSOR_WRAP_EN
        add(5'b10000, 2, 0, 3, 1'b1, 1'b0);
        add(5'b00000, 2, 0, 3, 1'b1, 1'b0);
        add(5'b00100, 2, 2, 3, 1'b1, 1'b0);
`else
        add(5'b10000, 0, 0, 3, 1'b1, 1'b0);
        add(5'b00000, 0, 0, 3, 1'b1, 1'b0);
        add(5'b00100, 0, 0, 3, 1'b1, 1'b0);
`endif

        do_reset;
        #1;
        check("reset", 0, 0, 0, 1'b0, 1'b0);

        foreach (tbl[i]) begin
            drive(tbl[i].in);
            tick;
            nm = $sformatf("vec%0d", i);
            check(nm, tbl[i].fila, tbl[i].col, tbl[i].fig, tbl[i].val, tbl[i].ent);
        end

        // Hold Derecha: moves at cycles 0, 4, 6, 8
        do_reset;
        drive(5'b00010);
        for (int i = 0; i < 10; i++) begin
            tick;
            nm = $sformatf("hold%0d", i);
            check(nm, 0, cexp[i], 0, 1'b0, 1'b0);
        end
        drive(5'b00000);
        tick;
        check("hold_release", 0, endc, 0, 1'b0, 1'b0);

        // Two directions together count as none
        drive(5'b10100);
        for (int i = 0; i < 5; i++) tick;
        check("multi_hot", 0, endc, 0, 1'b0, 1'b0);
        drive(5'b00000);
        tick;

        // Corner (2,2) then Abajo
        do_reset;
        for (int i = 0; i < 4; i++) begin
            drive(i < 2 ? 5'b00010 : 5'b01000);
            tick;
            drive(5'b00000);
            tick;
        end
        check("corner22", 2, 2, 0, 1'b0, 1'b0);
        drive(5'b01000);
        tick;
`ifdef CURSOR_WRAP_EN
        check("abajo_edge", 0, 2, 0, 1'b0, 1'b0);
`else
        check("abajo_edge", 2, 2, 0, 1'b0, 1'b0);
`endif
        drive(5'b00000);
        tick;

        // Index 5, confirm, then inactivity timeout
        do_reset;
        drive(5'b00010); tick; drive(5'b00000); tick;
        drive(5'b00010); tick; drive(5'b00000); tick;
        drive(5'b01000); tick; drive(5'b00000); tick;
        check("index5", 1, 2, 0, 1'b0, 1'b0);
        drive(5'b00001);
        tick;
        check("confirm5", 1, 2, 5, 1'b1, 1'b1);
        drive(5'b00000);
        tick;
        check("unlock", 1, 2, 5, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick;
        check("not_timed_out", 1, 2, 5, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) tick;
        check("timeout_home", 0, 0, 5, 1'b1, 1'b0);

        // Reset in the middle of a hold
        drive(5'b01000);
        tick;
        check("hold_start", 1, 0, 5, 1'b1, 1'b0);
        tick;
        tick;
        Reset = 1'b1;
        tick;
        check("reset_mid_hold", 0, 0, 0, 1'b0, 1'b0);
        Reset = 1'b0;
        drive(5'b00000);
        tick;
        check("after_reset", 0, 0, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/controlador_cursor.md
Name: controlador_cursor

Overview:
- Cursor/menu controller for the 3x3 shape-selection grid.
- Takes the five debounced push-button levels from the Filtro instances: Arriba, Abajo, Izquierda, Derecha, Select.
- Sequences a cursor over nine shapes, with edge-triggered moves and hold-to-auto-repeat.
- On Select, latches the chosen shape and issues a one-cycle Enter pulse; an inactivity timeout returns the cursor home.

Parameters:
- REPEAT_DELAY, 50000000, cycles a direction must be held before the first auto-repeat move.
- REPEAT_PERIOD, 10000000, cycles between later auto-repeat moves while still held.
- TIMEOUT, 500000000, cycles of all-inputs-low in IDLE before the cursor returns home.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Arriba  input  1  debounced up level.
- Abajo  input  1  debounced down level.
- Izquierda  input  1  debounced left level.
- Derecha  input  1  debounced right level.
- Select  input  1  debounced confirm level.
- Cursor  output  9  one-hot highlighted shape; bit i = index i.
- Fila  output  2  cursor row, 0..2.
- Columna  output  2  cursor column, 0..2.
- Figura  output  4  last confirmed shape index, 0..8.
- Valida  output  1  high once any shape has been confirmed.
- Enter  output  1  one-cycle pulse on confirm.

Behaviour:
- Indexing: index = 3*Fila + Columna.
  - Order: 0 circulo, 1 cuadrado, 2 triangulo, 3 ovalo, 4 rectangulo, 5 rombo, 6 hexagono, 7 pentagono, 8 estrella.
  - Cursor is always the one-hot decode of index and is registered.
- Reset values (synchronous, overrides everything, including mid-hold or mid-lock):
  - Fila=0, Columna=0, Cursor=9'b000000001.
  - Figura=0, Valida=0, Enter=0.
  - State IDLE; all counters 0; previous-input register cleared.
- Previous-input register: holds last cycle's {Arriba,Abajo,Izquierda,Derecha,Select}.
- Direction vector D = {Arriba,Abajo,Izquierda,Derecha}.
  - A "fresh press" = D is one-hot AND D differs from previous D.
  - If more than one direction bit is high, D is treated as no direction.
- Select edge = Select high and previous Select low.
- Select edge has priority over any direction in the same cycle.
- Move latency: a fresh press sampled at edge k updates Fila/Columna/Cursor at edge k; new values are visible after edge k.
- Move rules:
  - Arriba: Fila-1. Abajo: Fila+1. Izquierda: Columna-1. Derecha: Columna+1.
  - Edge handling is per CURSOR_WRAP_EN (see Optional Feature).
- States:
  - IDLE:
    - Fresh press -> move, counter=0, -> HOLD.
    - Select edge -> confirm.
    - Otherwise, if all five inputs are low, the inactivity counter increments. When it reaches TIMEOUT-1, the cursor goes to (0,0) and the counter clears; Figura and Valida are unchanged.
    - Any input high clears the inactivity counter.
  - HOLD:
    - Same D held -> counter increments.
    - At REPEAT_DELAY-1 -> move, counter=0, -> REPEAT.
  - REPEAT:
    - Same D held -> counter increments.
    - At REPEAT_PERIOD-1 -> move, counter=0.
  - HOLD/REPEAT exits:
    - Fresh press of a different direction -> move, counter=0, -> HOLD.
    - D becomes zero or multi-hot -> IDLE, no move.
    - Select edge -> confirm.
  - Confirm (any non-LOCK state):
    - Figura<=index, Valida<=1, Enter=1 for exactly one cycle, -> LOCK.
  - LOCK:
    - All inputs ignored; the cursor is frozen.
    - -> IDLE on the first cycle all five inputs are low; the inactivity counter starts from 0.
    - No Enter is issued while in LOCK.
- Counters: widths from $clog2 of the parameter; no overflow beyond the terminal value.

Optional Feature:
- Macro: CURSOR_WRAP_EN.
- Defined: moves wrap around the grid.
  - Derecha at Columna 2 -> Columna 0, same row; Izquierda at 0 -> 2.
  - Abajo at Fila 2 -> Fila 0; Arriba at 0 -> 2.
- Undefined: moves saturate at the grid edges; a move at an edge leaves the position unchanged.
  - The HOLD/REPEAT state and counters still advance as if a move occurred.

Test Plan (REPEAT_DELAY=4, REPEAT_PERIOD=2, TIMEOUT=8):
1. Reset high 2 cycles, then low -> Cursor=001h, Fila=0, Columna=0, Valida=0, Enter=0.
2. Derecha pulse 1 cycle, then Abajo pulse 1 cycle -> Cursor=010h (index 4); Select pulse -> Enter high exactly 1 cycle, Figura=4, Valida=1; further Derecha ignored while Select is still high.
3. Hold Derecha 10 cycles from (0,0) with wrap enabled -> moves at cycle 0, 4, 6, 8 -> columns 1,2,0,1; Cursor=002h at the end.
4. Arriba and Izquierda high together 5 cycles -> no move; Cursor unchanged.
5. At (2,2), Abajo pulse -> wrap build: Fila=0, Cursor=004h; no-wrap build: Fila=2, Cursor=100h.
6. Move to index 5, idle 8 cycles -> Cursor=001h, Figura/Valida unchanged; Reset asserted mid-HOLD -> all outputs return to reset values next cycle.
